onehot0_encoder: RTL and testbench

- Encodes a request vector that should be zero-hot or one-hot into a binary index.
- A single registered stage with valid/ready handshake on both sides.
- Flags and counts vectors with more than one bit set, i.e. violations of unique0 exclusivity.
- Sits downstream of condition-decode logic and feeds index-based selection/muxing; violation status goes to a debug/status register.

---
 rtl/onehot0_encoder_if.sv | 38 +++
 rtl/onehot0_encoder.sv | 146 ++++++++++++++
 tb/tb_onehot0_encoder.sv | 210 +++++++++++++++++++++
 3 files changed

// File: rtl/onehot0_encoder_if.sv
// Valid/ready bundle carrying request vectors into the encoder and indices out of it.
// The master side feeds vectors and accepts results; the slave side is the encoder.
interface onehot0_encoder_if #(
    parameter int N = 8
);
    localparam int IDXW = $clog2(N);

    logic            in_valid;
    logic            in_ready;
    logic [N-1:0]    in_vec;
    logic            out_valid;
    logic            out_ready;
    logic [IDXW-1:0] out_idx;
    logic            out_hit;
    logic            out_multi;

    modport master (
        output in_valid,
        output in_vec,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  out_idx,
        input  out_hit,
        input  out_multi
    );

    modport slave (
        input  in_valid,
        input  in_vec,
        input  out_ready,
        output in_ready,
        output out_valid,
        output out_idx,
        output out_hit,
        output out_multi
    );
endinterface

// File: rtl/onehot0_encoder.sv
// Registered zero-hot/one-hot to binary encoder with a saturating violation counter.
// Optional macro ONEHOT0_ENCODER_REPORT_EN adds simulation-only violation messages and a stall check.
module onehot0_encoder #(
    parameter int N    = 8,
    parameter int CNTW = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                clr_viol,
    onehot0_encoder_if.slave    bus,
    output logic [CNTW-1:0]     viol_cnt,
    output logic                viol_sticky
);
    localparam int IDXW = $clog2(N);

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_e;

    state_e          r_state;
    state_e          w_state_nxt;

    logic [IDXW-1:0] r_idx;
    logic            r_hit;
    logic            r_multi;
    logic [CNTW-1:0] r_viol_cnt;
    logic            r_viol_sticky;

    logic            w_in_ready;
    logic            w_in_accept;
    logic            w_out_accept;
    logic [IDXW-1:0] w_enc_idx;
    logic            w_enc_hit;
    logic            w_enc_multi;
    logic [CNTW-1:0] w_cnt_nxt;
    logic            w_sticky_nxt;

    // A full stage can still take a new vector when the consumer drains it this cycle.
    assign w_in_ready   = (r_state == EMPTY) || bus.out_ready;
    assign w_in_accept  = bus.in_valid && w_in_ready;
    assign w_out_accept = (r_state == FULL) && bus.out_ready;

    // NOTE: every variable gets a default before any branch, so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        w_enc_idx = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (bus.in_vec[i]) begin
                w_enc_idx = IDXW'(i);
            end
        end
    end

    assign w_enc_hit   = |bus.in_vec;
    // Clearing the lowest set bit leaves something behind only if two or more were set.
    assign w_enc_multi = |(bus.in_vec & (bus.in_vec - N'(1)));

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            EMPTY: begin
                if (w_in_accept) begin
                    w_state_nxt = FULL;
                end
            end
            FULL: begin
                if (w_in_accept) begin
                    w_state_nxt = FULL;
                end else if (w_out_accept) begin
                    w_state_nxt = EMPTY;
                end
            end
            default: w_state_nxt = EMPTY;
        endcase
    end

    // A violation accepted together with a clear restarts the count at one.
    always_comb begin
        w_cnt_nxt    = r_viol_cnt;
        w_sticky_nxt = r_viol_sticky;
        if (w_in_accept && w_enc_multi) begin
            w_sticky_nxt = 1'b1;
            if (clr_viol) begin
                w_cnt_nxt = CNTW'(1);
            end else if (!(&r_viol_cnt)) begin
                w_cnt_nxt = r_viol_cnt + CNTW'(1);
            end
        end else if (clr_viol) begin
            w_cnt_nxt    = '0;
            w_sticky_nxt = 1'b0;
        end
    end

    // NOTE: state is updated with non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= EMPTY;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_idx   <= '0;
            r_hit   <= 1'b0;
            r_multi <= 1'b0;
        end else if (w_in_accept) begin
            r_idx   <= w_enc_idx;
            r_hit   <= w_enc_hit;
            r_multi <= w_enc_multi;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_viol_cnt    <= '0;
            r_viol_sticky <= 1'b0;
        end else begin
            r_viol_cnt    <= w_cnt_nxt;
            r_viol_sticky <= w_sticky_nxt;
        end
    end

    assign bus.in_ready  = w_in_ready;
    assign bus.out_valid = (r_state == FULL);
    assign bus.out_idx   = r_idx;
    assign bus.out_hit   = r_hit;
    assign bus.out_multi = r_multi;
    assign viol_cnt      = r_viol_cnt;
    assign viol_sticky   = r_viol_sticky;

`ifdef ONEHOT0_ENCODER_REPORT_EN
    always @(posedge clk) begin
        if (rst_n && w_in_accept && w_enc_multi) begin
            $display("ONEHOT0 violation: vec=%b idx=%0d", bus.in_vec, w_enc_idx);
        end
        if (rst_n && (r_state == FULL) && !bus.out_ready) begin
            assert (w_state_nxt == FULL)
            else $error("onehot0_encoder: out_valid dropped while out_ready=0");
        end
    end
`else
`endif

endmodule

// File: tb/tb_onehot0_encoder.sv
// Bench for onehot0_encoder: two instances (CNTW=8 and CNTW=2) share one stimulus stream
// and are compared every cycle against a transaction-level model of the stage.
module tb_onehot0_encoder;
    localparam int N = 8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n;
    logic       clr_viol;
    logic [7:0] viol_cnt8;
    logic       viol_sticky8;
    logic [1:0] viol_cnt2;
    logic       viol_sticky2;

    onehot0_encoder_if #(.N(N)) bus8 ();
    onehot0_encoder_if #(.N(N)) bus2 ();

    onehot0_encoder #(.N(N), .CNTW(8)) u_dut8 (
        .clk         (clk),
        .rst_n       (rst_n),
        .clr_viol    (clr_viol),
        .bus         (bus8),
        .viol_cnt    (viol_cnt8),
        .viol_sticky (viol_sticky8)
    );

    onehot0_encoder #(.N(N), .CNTW(2)) u_dut2 (
        .clk         (clk),
        .rst_n       (rst_n),
        .clr_viol    (clr_viol),
        .bus         (bus2),
        .viol_cnt    (viol_cnt2),
        .viol_sticky (viol_sticky2)
    );

    int checks = 0;
    int errors = 0;

    // Reference model: one result slot plus violation bookkeeping.
    bit m_valid  = 1'b0;
    int m_idx    = 0;
    bit m_hit    = 1'b0;
    bit m_multi  = 1'b0;
    int m_cnt8   = 0;
    int m_cnt2   = 0;
    bit m_sticky = 1'b0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int lowest_set(input logic [7:0] vec);
        for (int j = 0; j < 8; j++) begin
            if (vec[j]) return j;
        end
        return 0;
    endfunction

    function automatic int sat_inc(input int val, input int max);
        return (val >= max) ? max : val + 1;
    endfunction

    // One clock: drive inputs, check in_ready, advance the model, check registered outputs.
    task automatic step(input logic v, input logic [7:0] vec, input logic ordy,
                        input logic clr, input logic rst);
        bit acc;
        bit multi;
        bus8.in_valid  = v;    bus2.in_valid  = v;
        bus8.in_vec    = vec;  bus2.in_vec    = vec;
        bus8.out_ready = ordy; bus2.out_ready = ordy;
        clr_viol = clr;
        rst_n    = rst;
        #1;
        check("in_ready8", bus8.in_ready, !m_valid || ordy);
        check("in_ready2", bus2.in_ready, !m_valid || ordy);

        acc   = v && (!m_valid || ordy);
        multi = ($countones(vec) > 1);
        if (!rst) begin
            m_valid = 0; m_idx = 0; m_hit = 0; m_multi = 0;
            m_cnt8 = 0; m_cnt2 = 0; m_sticky = 0;
        end else begin
            if (acc && multi) begin
                m_cnt8   = clr ? 1 : sat_inc(m_cnt8, 255);
                m_cnt2   = clr ? 1 : sat_inc(m_cnt2, 3);
                m_sticky = 1;
            end else if (clr) begin
                m_cnt8 = 0; m_cnt2 = 0; m_sticky = 0;
            end
            if (acc) begin
                m_valid = 1;
                m_idx   = lowest_set(vec);
                m_hit   = (vec != 8'h00);
                m_multi = multi;
            end else if (m_valid && ordy) begin
                m_valid = 0;
            end
        end

        @(posedge clk);
        #1;
        check("out_valid8", bus8.out_valid, m_valid);
        check("out_idx8",   bus8.out_idx,   m_idx);
        check("out_hit8",   bus8.out_hit,   m_hit);
        check("out_multi8", bus8.out_multi, m_multi);
        check("out_valid2", bus2.out_valid, m_valid);
        check("out_idx2",   bus2.out_idx,   m_idx);
        check("out_hit2",   bus2.out_hit,   m_hit);
        check("out_multi2", bus2.out_multi, m_multi);
        check("viol_cnt8",  viol_cnt8,      m_cnt8);
        check("viol_cnt2",  viol_cnt2,      m_cnt2);
        check("sticky8",    viol_sticky8,   m_sticky);
        check("sticky2",    viol_sticky2,   m_sticky);
    endtask

    initial begin
        logic [7:0] rvec;
        int         kind;

        // Reset state
        step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
        step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
        check("rst_valid", bus8.out_valid, 1'b0);
        check("rst_cnt",   viol_cnt8,      8'd0);

        // Zero-hot: hit=0 distinguishes it from bit 0
        step(1'b1, 8'h00, 1'b1, 1'b0, 1'b1);
        check("zero_valid", bus8.out_valid, 1'b1);
        check("zero_hit",   bus8.out_hit,   1'b0);
        check("zero_idx",   bus8.out_idx,   3'd0);

        // Back-to-back one-hot stream, no bubbles
        step(1'b1, 8'h01, 1'b1, 1'b0, 1'b1);
        check("bit0_hit", bus8.out_hit, 1'b1);
        check("bit0_idx", bus8.out_idx, 3'd0);
        step(1'b1, 8'h20, 1'b1, 1'b0, 1'b1);
        check("bit5_idx", bus8.out_idx, 3'd5);
        step(1'b1, 8'h80, 1'b1, 1'b0, 1'b1);
        check("bit7_idx", bus8.out_idx, 3'd7);
        check("stream_in_ready", bus8.in_ready, 1'b1);

        // Multi-hot violation
        step(1'b1, 8'h50, 1'b1, 1'b0, 1'b1);
        check("viol_idx",    bus8.out_idx,   3'd4);
        check("viol_multi",  bus8.out_multi, 1'b1);
        check("viol_cnt1",   viol_cnt8,      8'd1);
        check("viol_sticky", viol_sticky8,   1'b1);

        // Backpressure: result held, new vector refused
        step(1'b1, 8'h08, 1'b1, 1'b0, 1'b1);
        for (int k = 0; k < 3; k++) begin
            step(1'b1, 8'hFF, 1'b0, 1'b0, 1'b1);
            check("bp_in_ready", bus8.in_ready, 1'b0);
            check("bp_idx",      bus8.out_idx,  3'd3);
        end
        step(1'b1, 8'h04, 1'b1, 1'b0, 1'b1);
        check("bp_release_idx", bus8.out_idx, 3'd2);
        step(1'b0, 8'h00, 1'b1, 1'b0, 1'b1);

        // Saturation on CNTW=2, then clear alone and clear with a violation
        step(1'b0, 8'h00, 1'b1, 1'b1, 1'b1);
        check("clr_cnt2", viol_cnt2, 2'd0);
        for (int k = 0; k < 5; k++) begin
            step(1'b1, 8'h0C, 1'b1, 1'b0, 1'b1);
            check("sat_cnt2", viol_cnt2, (k < 3) ? k + 1 : 3);
        end
        step(1'b0, 8'h00, 1'b1, 1'b1, 1'b1);
        check("clr_alone_cnt",    viol_cnt2,    2'd0);
        check("clr_alone_sticky", viol_sticky2, 1'b0);
        step(1'b1, 8'h81, 1'b1, 1'b1, 1'b1);
        check("clr_viol_cnt2", viol_cnt2, 2'd1);
        check("clr_viol_cnt8", viol_cnt8, 8'd1);

        // Saturation on CNTW=8
        for (int k = 0; k < 258; k++) begin
            step(1'b1, 8'hC0, 1'b1, 1'b0, 1'b1);
        end
        check("sat_cnt8", viol_cnt8, 8'd255);

        // Randomized traffic
        for (int k = 0; k < 400; k++) begin
            kind = $urandom_range(0, 2);
            if (kind == 0)      rvec = 8'h00;
            else if (kind == 1) rvec = 8'h01 << $urandom_range(0, 7);
            else                rvec = 8'($urandom);
            step(1'($urandom_range(0, 3) != 0), rvec, 1'($urandom_range(0, 2) != 0),
                 1'($urandom_range(0, 15) == 0), 1'($urandom_range(0, 63) != 0));
        end

        // Reset while FULL and stalled: held result is discarded
        step(1'b0, 8'h00, 1'b1, 1'b0, 1'b1);
        step(1'b1, 8'h30, 1'b0, 1'b0, 1'b1);
        check("pre_rst_valid", bus8.out_valid, 1'b1);
        step(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
        check("mid_rst_valid", bus8.out_valid, 1'b0);
        check("mid_rst_idx",   bus8.out_idx,   3'd0);
        check("mid_rst_cnt",   viol_cnt8,      8'd0);
        step(1'b0, 8'h00, 1'b1, 1'b0, 1'b1);
        check("post_rst_valid", bus8.out_valid, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
